// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and operation helpers for the M-extension multiply/divide unit.
package ex_muldiv_unit_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int RS_WIDTH_DEF = 5;

   typedef enum logic [2:0] {
      MULDIV_MUL    = 3'b000,
      MULDIV_MULH   = 3'b001,
      MULDIV_MULHSU = 3'b010,
      MULDIV_MULHU  = 3'b011,
      MULDIV_DIV    = 3'b100,
      MULDIV_DIVU   = 3'b101,
      MULDIV_REM    = 3'b110,
      MULDIV_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } muldiv_state_e;

   typedef enum logic {
      ITER_MUL,
      ITER_DIV
   } iter_mode_e;

   function automatic logic op_signed_a(input logic [2:0] f3);
      return (f3 == MULDIV_MUL) || (f3 == MULDIV_MULH) || (f3 == MULDIV_MULHSU) ||
             (f3 == MULDIV_DIV) || (f3 == MULDIV_REM);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] f3);
      return (f3 == MULDIV_MUL) || (f3 == MULDIV_MULH) ||
             (f3 == MULDIV_DIV) || (f3 == MULDIV_REM);
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage handshake between the pipeline (master) and the multiply/divide unit (slave).
interface ex_muldiv_unit_if #(
   parameter int XLEN     = 32,
   parameter int RS_WIDTH = 5
);
   logic                in_valid;
   logic [2:0]          funct3;
   logic [XLEN-1:0]     op_a;
   logic [XLEN-1:0]     op_b;
   logic [RS_WIDTH-1:0] rd_in;
   logic                flush;
   logic                stall;
   logic                out_valid;
   logic [XLEN-1:0]     result;
   logic [RS_WIDTH-1:0] rd_out;

   modport master (
      output in_valid, funct3, op_a, op_b, rd_in, flush,
      input  stall, out_valid, result, rd_out
   );

   modport slave (
      input  in_valid, funct3, op_a, op_b, rd_in, flush,
      output stall, out_valid, result, rd_out
   );
endinterface

// File: rtl/ex_muldiv_iter.sv
// One combinational step of the shared datapath: shift-add for multiply,
// restoring trial-subtract for divide. acc is {hi, lo}.
module ex_muldiv_iter
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   input  iter_mode_e        mode,
   output logic [2*XLEN-1:0] acc_next
);

   logic [XLEN:0] sum;
   logic [XLEN:0] diff;

   // Multiply: add into hi when lo[0] is set, then shift the whole product right.
   assign sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : {XLEN{1'b0}})};
   // Divide: the shifted partial remainder needs XLEN+1 bits before the trial subtract.
   assign diff = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};

   always_comb begin
      acc_next = acc;
      if (mode == ITER_MUL) begin
         acc_next = {sum, acc[XLEN-1:1]};
      end else if (diff[XLEN]) begin
         acc_next = {acc[2*XLEN-2:0], 1'b0};
      end else begin
         acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M execute unit: sign handling, special cases and sequencing
// around the shared ex_muldiv_iter step.
//   state   | meaning
//   IDLE    | waiting for an M-op; accepts on in_valid & !flush
//   MUL     | XLEN shift-add steps on magnitudes
//   DIV     | XLEN restoring-subtract steps on magnitudes
//   DONE    | result presented for one cycle, pipeline advances
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int RS_WIDTH = RS_WIDTH_DEF
) (
   input logic             clk,
   input logic             rst,
   ex_muldiv_unit_if.slave bus
);

   localparam int              CW      = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e       state_q;
   logic [CW-1:0]       cnt_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [XLEN-1:0]     opnd_q;
   logic [2:0]          f3_q;
   logic                a_neg_q;
   logic                b_neg_q;
   logic [XLEN-1:0]     result_q;
   logic [RS_WIDTH-1:0] rd_q;

   logic              a_sgn, b_sgn;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   special_res;
   logic [2*XLEN-1:0] acc_nxt;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

   assign a_sgn    = op_signed_a(bus.funct3) & bus.op_a[XLEN-1];
   assign b_sgn    = op_signed_b(bus.funct3) & bus.op_b[XLEN-1];
   assign a_mag    = a_sgn ? -bus.op_a : bus.op_a;
   assign b_mag    = b_sgn ? -bus.op_b : bus.op_b;
   assign div_zero = bus.funct3[2] & (bus.op_b == '0);
   assign div_ovf  = bus.funct3[2] & ~bus.funct3[0] & (bus.op_a == MIN_NEG) & (bus.op_b == '1);

   // funct3[1] separates REM* from DIV*.
   assign special_res = div_zero ? (bus.funct3[1] ? bus.op_a : '1)
                                 : (bus.funct3[1] ? '0 : bus.op_a);

   ex_muldiv_iter #(.XLEN(XLEN)) u_iter (
      .acc      (acc_q),
      .operand  (opnd_q),
      .mode     ((state_q == ST_DIV) ? ITER_DIV : ITER_MUL),
      .acc_next (acc_nxt)
   );

   assign prod    = (a_neg_q ^ b_neg_q) ? -acc_nxt : acc_nxt;
   assign quo_fix = (a_neg_q ^ b_neg_q) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
   assign rem_fix = a_neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
   assign fin_res = (state_q == ST_MUL)
                    ? ((f3_q == MULDIV_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                    : (f3_q[1] ? rem_fix : quo_fix);

   assign bus.stall     = rst & (((state_q == ST_IDLE) & bus.in_valid & ~bus.flush) |
                                 (state_q == ST_MUL) | (state_q == ST_DIV));
   assign bus.out_valid = (state_q == ST_DONE) & ~bus.flush;
   assign bus.result    = result_q;
   assign bus.rd_out    = rd_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         f3_q     <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
      end else if (bus.flush) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  f3_q    <= bus.funct3;
                  rd_q    <= bus.rd_in;
                  a_neg_q <= a_sgn;
                  b_neg_q <= b_sgn;
                  cnt_q   <= CW'(XLEN-1);
                  if (!bus.funct3[2]) begin
                     acc_q   <= {{XLEN{1'b0}}, b_mag};
                     opnd_q  <= a_mag;
                     state_q <= ST_MUL;
                  end else if (div_zero || div_ovf) begin
                     result_q <= special_res;
                     state_q  <= ST_DONE;
                  end else begin
                     acc_q   <= {{XLEN{1'b0}}, a_mag};
                     opnd_q  <= b_mag;
                     state_q <= ST_DIV;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               acc_q <= acc_nxt;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  result_q <= fin_res;
                  state_q  <= ST_DONE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
